// File: rtl/cfu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cfu_pkg
//  Description : Shared widths and request/completion types for the CFU
//                issue path.
//  Revision    : 1.0  initial release
// ============================================================================
package cfu_pkg;

    localparam int CFU_DATA_W   = 32;
    localparam int CFU_SEL_W    = 8;
    localparam int CFU_FUNC_W   = 10;
    localparam int CFU_STATUS_W = 3;
    localparam int CFU_ID_W     = 3;

    typedef struct packed {
        logic [CFU_SEL_W-1:0]  cfu;
        logic [CFU_FUNC_W-1:0] func;
        logic [CFU_DATA_W-1:0] data0;
        logic [CFU_DATA_W-1:0] data1;
        logic [CFU_ID_W-1:0]   id;
    } cfu_req_t;

    typedef struct packed {
        logic [CFU_ID_W-1:0]   id;
        logic [CFU_DATA_W-1:0] data;
        logic                  error;
    } cfu_cpl_t;

endpackage
`default_nettype wire

// File: rtl/cfu_interface.sv
`default_nettype none
// ============================================================================
//  Module      : cfu_interface
//  Description : Request/response channel between the processor and a CFU.
//  Revision    : 1.0  initial release
// ============================================================================
interface cfu_interface
    import cfu_pkg::*;
#(
    parameter int ID_W = 3
);
    logic                    req_valid;
    logic                    req_ready;
    logic [CFU_SEL_W-1:0]    req_cfu;
    logic [CFU_FUNC_W-1:0]   req_func;
    logic [CFU_DATA_W-1:0]   req_data0;
    logic [CFU_DATA_W-1:0]   req_data1;
    logic [ID_W-1:0]         req_id;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [ID_W-1:0]         resp_id;
    logic [CFU_STATUS_W-1:0] resp_status;
    logic [CFU_DATA_W-1:0]   resp_data;

    modport master (
        output req_valid, req_cfu, req_func, req_data0, req_data1, req_id,
        input  req_ready,
        input  resp_valid, resp_id, resp_status, resp_data,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_cfu, req_func, req_data0, req_data1, req_id,
        output req_ready,
        output resp_valid, resp_id, resp_status, resp_data,
        input  resp_ready
    );

endinterface
`default_nettype wire

// File: rtl/cfu_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cfu_tag_fifo
//  Description : In-order FIFO of instruction IDs for operations in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module cfu_tag_fifo
    import cfu_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Explicit wrap keeps the pointers correct even for a depth of one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cfu_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cfu_issue_unit
//  Description : Issues CFU operations from execute, tracks in-order tags and
//                returns completions to writeback. Define CFU_WATCHDOG_EN to
//                enable the response-timeout watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module cfu_issue_unit
    import cfu_pkg::*;
#(
    parameter int MAX_INFLIGHT   = 4,
    parameter int ID_W           = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [CFU_DATA_W-1:0] issue_rs1,
    input  logic [CFU_DATA_W-1:0] issue_rs2,
    input  logic [CFU_SEL_W-1:0]  issue_cfu,
    input  logic [CFU_FUNC_W-1:0] issue_func,
    input  logic [ID_W-1:0]       issue_id,
    output logic                  wb_valid,
    input  logic                  wb_ack,
    output logic [ID_W-1:0]       wb_id,
    output logic [CFU_DATA_W-1:0] wb_data,
    output logic                  wb_error,
    cfu_interface.master          cfu
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 16) begin : g_bad_depth
        $error("MAX_INFLIGHT must be in 1..16");
    end

    logic        r_req_valid;
    cfu_req_t    r_req;
    logic        r_wb_valid;
    cfu_cpl_t    r_wb;

    logic        w_full;
    logic        w_empty;
    logic [ID_W-1:0] w_head_tag;
    logic        w_issue_acc;
    logic        w_wb_free;
    logic        w_resp_acc;
    logic        w_resp_pop;
    logic        w_timeout;
    logic        w_pop;

    // Registered full only: a pop this cycle does not open a slot until next.
    assign issue_ready = !w_full & (!r_req_valid | cfu.req_ready);
    assign w_issue_acc = issue_valid & issue_ready;

    assign w_wb_free      = !r_wb_valid | wb_ack;
    assign cfu.resp_ready = w_wb_free;
    assign w_resp_acc     = cfu.resp_valid & w_wb_free;
    assign w_resp_pop     = w_resp_acc & !w_empty;
    assign w_pop          = w_resp_pop | w_timeout;

    cfu_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_issue_acc),
        .i_pop   (w_pop),
        .i_data  (issue_id),
        .o_data  (w_head_tag),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid <= 1'b0;
        end else if (w_issue_acc) begin
            r_req_valid <= 1'b1;
        end else if (cfu.req_ready) begin
            r_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue_acc) begin
            r_req.cfu   <= issue_cfu;
            r_req.func  <= issue_func;
            r_req.data0 <= issue_rs1;
            r_req.data1 <= issue_rs2;
            r_req.id    <= issue_id;
        end
    end

    assign cfu.req_valid = r_req_valid;
    assign cfu.req_cfu   = r_req.cfu;
    assign cfu.req_func  = r_req.func;
    assign cfu.req_data0 = r_req.data0;
    assign cfu.req_data1 = r_req.data1;
    assign cfu.req_id    = r_req.id;

`ifdef CFU_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            w_wd_hit;

    // Fires on the cycle the head has waited TIMEOUT_CYCLES, so the forced
    // completion lands exactly TIMEOUT_CYCLES after the FIFO became non-empty.
    assign w_wd_hit  = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign w_timeout = !w_empty & w_wd_hit & w_wb_free & !w_resp_acc;

    always_ff @(posedge clk) begin
        if (rst || w_empty || w_resp_acc || w_timeout) begin
            r_wd_cnt <= '0;
        end else if (!w_wd_hit) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb       <= '0;
        end else if (w_resp_pop) begin
            r_wb_valid <= 1'b1;
            r_wb.id    <= w_head_tag;
            r_wb.data  <= cfu.resp_data;
            r_wb.error <= (cfu.resp_status != '0) | (cfu.resp_id != w_head_tag);
        end else if (w_timeout) begin
            r_wb_valid <= 1'b1;
            r_wb.id    <= w_head_tag;
            r_wb.data  <= '0;
            r_wb.error <= 1'b1;
        end else if (wb_ack) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_id    = r_wb.id;
    assign wb_data  = r_wb.data;
    assign wb_error = r_wb.error;

endmodule
`default_nettype wire

// File: tb/tb_cfu_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfu_issue_unit
//  Description : Directed bench for cfu_issue_unit with a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cfu_issue_unit;

    localparam int MAX = 4;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_rs1, issue_rs2;
    logic [7:0]  issue_cfu;
    logic [9:0]  issue_func;
    logic [2:0]  issue_id;
    logic        wb_valid, wb_ack, wb_error;
    logic [2:0]  wb_id;
    logic [31:0] wb_data;

    cfu_interface #(.ID_W(3)) cfu_if ();

    cfu_issue_unit #(
        .MAX_INFLIGHT   (MAX),
        .ID_W           (3),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_cfu   (issue_cfu),
        .issue_func  (issue_func),
        .issue_id    (issue_id),
        .wb_valid    (wb_valid),
        .wb_ack      (wb_ack),
        .wb_id       (wb_id),
        .wb_data     (wb_data),
        .wb_error    (wb_error),
        .cfu         (cfu_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: tags in flight, pending request and completion register
    logic [2:0]  q[$];
    bit          started = 0;
    bit          m_req_valid;
    logic [31:0] m_rs1, m_rs2;
    logic [7:0]  m_cfu;
    logic [9:0]  m_func;
    logic [2:0]  m_rid;
    bit          m_wb_valid;
    logic [2:0]  m_wb_id;
    logic [31:0] m_wb_data;
    bit          m_wb_err;
    int          m_wait;

    always @(posedge clk) begin
        bit ir, rr, iacc, racc, had, tmo;
        logic [2:0] tag;
        if (rst) begin
            q.delete();
            m_req_valid = 0;
            m_wb_valid  = 0;
            m_wb_err    = 0;
            m_wait      = 0;
            started     = 1;
        end else if (started) begin
            ir   = (q.size() < MAX) && (!m_req_valid || cfu_if.req_ready);
            rr   = !m_wb_valid || wb_ack;
            iacc = issue_valid && ir;
            racc = cfu_if.resp_valid && rr;
            had  = (q.size() > 0);
            tmo  = 0;
`ifdef CFU_WATCHDOG_EN
            tmo = had && !racc && rr && (m_wait == TO - 1);
`endif
            if (!had || racc || tmo) m_wait = 0;
            else if (m_wait < TO - 1) m_wait++;
            if (racc && had) begin
                tag        = q.pop_front();
                m_wb_valid = 1;
                m_wb_id    = tag;
                m_wb_data  = cfu_if.resp_data;
                m_wb_err   = (cfu_if.resp_status != 0) || (cfu_if.resp_id != tag);
            end else if (tmo) begin
                tag        = q.pop_front();
                m_wb_valid = 1;
                m_wb_id    = tag;
                m_wb_data  = 0;
                m_wb_err   = 1;
            end else if (wb_ack) begin
                m_wb_valid = 0;
            end
            if (iacc) begin
                q.push_back(issue_id);
                m_req_valid = 1;
                m_rs1 = issue_rs1; m_rs2 = issue_rs2;
                m_cfu = issue_cfu; m_func = issue_func; m_rid = issue_id;
            end else if (cfu_if.req_ready) begin
                m_req_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_issue_ready", issue_ready,
                  (q.size() < MAX) && (!m_req_valid || cfu_if.req_ready));
            check("m_resp_ready", cfu_if.resp_ready, !m_wb_valid || wb_ack);
            check("m_req_valid", cfu_if.req_valid, m_req_valid);
            if (m_req_valid) begin
                check("m_req_data0", cfu_if.req_data0, m_rs1);
                check("m_req_data1", cfu_if.req_data1, m_rs2);
                check("m_req_cfu",   cfu_if.req_cfu,   m_cfu);
                check("m_req_func",  cfu_if.req_func,  m_func);
                check("m_req_id",    cfu_if.req_id,    m_rid);
            end
            check("m_wb_valid", wb_valid, m_wb_valid);
            if (m_wb_valid) begin
                check("m_wb_id",    wb_id,    m_wb_id);
                check("m_wb_data",  wb_data,  m_wb_data);
                check("m_wb_error", wb_error, m_wb_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_issue(input logic [2:0] id, input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1; issue_id = id; issue_rs1 = a; issue_rs2 = b;
        issue_cfu = 8'(id + 1); issue_func = 10'(id * 3 + 7);
    endtask

    task automatic put_resp(input logic [2:0] id, input logic [2:0] st, input logic [31:0] d);
        cfu_if.resp_valid = 1; cfu_if.resp_id = id; cfu_if.resp_status = st; cfu_if.resp_data = d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_issue_ready"}, issue_ready, 1);
        check({tag, "_resp_ready"}, cfu_if.resp_ready, 1);
        check({tag, "_req_valid"}, cfu_if.req_valid, 0);
        check({tag, "_wb_valid"}, wb_valid, 0);
        check({tag, "_wb_error"}, wb_error, 0);
    endtask

    initial begin
        int k;
        rst = 1; issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_cfu = 0;
        issue_func = 0; issue_id = 0; wb_ack = 0;
        cfu_if.req_ready = 0; cfu_if.resp_valid = 0; cfu_if.resp_id = 0;
        cfu_if.resp_status = 0; cfu_if.resp_data = 0;
        repeat (3) tick();
        rst = 0;
        #1;
        check_reset_state("reset");

        // Single operation
        cfu_if.req_ready = 1; wb_ack = 1;
        put_issue(3'd2, 32'h5, 32'h3);
        tick();
        issue_valid = 0;
        check("single_req_valid", cfu_if.req_valid, 1);
        check("single_req_id", cfu_if.req_id, 2);
        check("single_req_data0", cfu_if.req_data0, 32'h5);
        put_resp(3'd2, 3'd0, 32'hABCD);
        tick();
        cfu_if.resp_valid = 0;
        check("single_wb_valid", wb_valid, 1);
        check("single_wb_id", wb_id, 2);
        check("single_wb_data", wb_data, 32'hABCD);
        check("single_wb_error", wb_error, 0);
        tick();
        check("single_wb_clear", wb_valid, 0);

        // Request backpressure, then completion backpressure
        cfu_if.req_ready = 0;
        put_issue(3'd1, 32'h11, 32'h22);
        tick();
        issue_valid = 0;
        #1;
        check("bp_issue_ready", issue_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_req_stable", cfu_if.req_data0, 32'h11);
        end
        cfu_if.req_ready = 1;
        tick();
        check("bp_req_drained", cfu_if.req_valid, 0);
        wb_ack = 0;
        put_resp(3'd1, 3'd0, 32'h77);
        tick();
        cfu_if.resp_valid = 0;
        check("bp_wb_valid", wb_valid, 1);
        check("bp_resp_ready_low", cfu_if.resp_ready, 0);
        tick();
        check("bp_wb_held", wb_valid, 1);
        wb_ack = 1;
        #1;
        check("bp_resp_ready_ack", cfu_if.resp_ready, 1);
        tick();

        // Fill to MAX_INFLIGHT, free one slot, accept the fifth
        for (int i = 0; i < 4; i++) begin
            put_issue(3'(i), 32'(i * 16), 32'(i + 100));
            tick();
        end
        put_issue(3'd4, 32'h44, 32'h55);
        put_resp(3'd0, 3'd0, 32'h1000);
        #1;
        check("fill_full_ready", issue_ready, 0);
        tick();
        cfu_if.resp_valid = 0;
        #1;
        check("fill_slot_free", issue_ready, 1);
        tick();
        issue_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            put_resp(3'(i), 3'd0, 32'(32'h1000 + i));
            tick();
            check("fill_drain_id", wb_id, 32'(i));
        end
        cfu_if.resp_valid = 0;
        tick();

        // ID mismatch and nonzero status
        put_issue(3'd1, 32'h9, 32'h8);
        tick();
        issue_valid = 0;
        put_resp(3'd3, 3'd0, 32'h55);
        tick();
        cfu_if.resp_valid = 0;
        check("mm_wb_id", wb_id, 1);
        check("mm_wb_error", wb_error, 1);
        put_issue(3'd6, 32'h1, 32'h2);
        tick();
        issue_valid = 0;
        put_resp(3'd6, 3'd2, 32'h66);
        tick();
        cfu_if.resp_valid = 0;
        check("st_wb_id", wb_id, 6);
        check("st_wb_error", wb_error, 1);
        tick();

        // Spurious response with nothing outstanding
        put_resp(3'd0, 3'd0, 32'hDEAD);
        #1;
        check("sp_resp_ready", cfu_if.resp_ready, 1);
        tick();
        cfu_if.resp_valid = 0;
        check("sp_no_wb", wb_valid, 0);
        tick();
        check("sp_no_wb_later", wb_valid, 0);

        // Unanswered operation
        put_issue(3'd5, 32'h3, 32'h4);
        tick();
        issue_valid = 0;
        k = 0;
        while (k < 40 && !wb_valid) begin
            tick();
            k++;
        end
`ifdef CFU_WATCHDOG_EN
        check("wd_latency", 32'(k), TO);
        check("wd_wb_id", wb_id, 5);
        check("wd_wb_data", wb_data, 0);
        check("wd_wb_error", wb_error, 1);
`else
        check("nowd_no_wb", wb_valid, 0);
`endif

        // Reset with an operation outstanding
        put_issue(3'd7, 32'h7, 32'h7);
        cfu_if.req_ready = 0;
        tick();
        issue_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        #1;
        check_reset_state("midrst");
        cfu_if.req_ready = 1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
